// File: rtl/nibble_serial_addsub.sv
// Multi-precision add/subtract: one 4-bit slice per clock, LSB nibble first, carry chained between nibbles.
// Optional SIGNED_OVERFLOW_FLAG_EN adds the ovf port (two's-complement overflow of the full-width operation).
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ctrl,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   q,
  output logic                   c_final,
  output logic                   zero
`ifdef SIGNED_OVERFLOW_FLAG_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  partial;
  logic          ctrl_r;
  logic          carry;
  logic [IW-1:0] idx;

  logic          accept;
  logic          last;
  logic [3:0]    b_nib;
  logic [4:0]    s;
  logic [W-1:0]  result;
  logic          carry_into_msb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    accept = (state == IDLE) && start;
    last   = (state == RUN) && (idx == IW'(NIBBLES - 1));
  end

  // Operands shift right each cycle so the active nibble always sits at [3:0];
  // idx only tracks completion, keeping the per-cycle path to a single slice.
  always_comb begin
    b_nib          = ctrl_r ? ~b_sh[3:0] : b_sh[3:0];
    s              = {1'b0, a_sh[3:0]} + {1'b0, b_nib} + {4'b0000, carry};
    result         = {s[3:0], partial[W-1:4]};
    carry_into_msb = a_sh[3] ^ b_nib[3] ^ s[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      ctrl_r  <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
      q       <= '0;
      c_final <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        ctrl_r  <= ctrl;
        carry   <= ctrl;
        partial <= '0;
        idx     <= '0;
      end else if (busy) begin
        a_sh    <= a_sh >> 4;
        b_sh    <= b_sh >> 4;
        partial <= result;
        carry   <= s[4];
        idx     <= idx + 1'b1;
        if (last) begin
          q       <= result;
          c_final <= s[4];
          zero    <= (result == '0);
          done    <= 1'b1;
        end
      end
    end
  end

`ifdef SIGNED_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)       ovf <= 1'b0;
    else if (last) ovf <= carry_into_msb ^ s[4];
  end
`else
  logic unused_ok;
  assign unused_ok = carry_into_msb;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: directed cases plus random operations against an arithmetic model.
module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] q;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ctrl;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         c_final;
  logic         zero;
`ifdef SIGNED_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int checks = 0;
  int passed = 0;

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ctrl    (ctrl),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .c_final (c_final),
    .zero    (zero)
`ifdef SIGNED_OVERFLOW_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain modulo-2^W arithmetic and signed-overflow rules.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    res_t r;
    logic [W:0] sum;
    if (!sub) begin
      sum = {1'b0, x} + {1'b0, y};
      r.q = sum[W-1:0];
      r.c = sum[W];
      r.v = (x[W-1] == y[W-1]) && (r.q[W-1] != x[W-1]);
    end else begin
      r.q = x - y;
      r.c = (x >= y);
      r.v = (x[W-1] != y[W-1]) && (r.q[W-1] != x[W-1]);
    end
    r.z = (r.q == '0);
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Presents a request and returns #1 after the accepting edge, scrambling inputs afterwards.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    ctrl  = sub;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    ctrl  = 1'($urandom);
  endtask

  // Walks edges first..NIBBLES after acceptance; returns #1 after the done edge.
  task automatic finish_op(input int first, input res_t e);
    for (int k = first; k < NIBBLES; k++) begin
      @(posedge clk);
      #1;
      check_bit("busy_run", busy, 1'b1);
      check_bit("done_early", done, 1'b0);
    end
    @(posedge clk);
    #1;
    check_bit("done_pulse", done, 1'b1);
    check_bit("busy_end", busy, 1'b0);
    check_vec("q", q, e.q);
    check_bit("c_final", c_final, e.c);
    check_bit("zero", zero, e.z);
`ifdef SIGNED_OVERFLOW_FLAG_EN
    check_bit("ovf", ovf, e.v);
`endif
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    res_t e;
    e = model(x, y, sub);
    start_op(x, y, sub);
    finish_op(1, e);
  endtask

  initial begin
    res_t e;
    logic [W-1:0] ra, rb;
    logic rc;

    rst   = 1'b1;
    start = 1'b0;
    ctrl  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_vec("rst_q", q, '0);
    check_bit("rst_c", c_final, 1'b0);
    check_bit("rst_zero", zero, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(16'h1234, 16'h0FFF, 1'b0);
    // done clears on the next edge and results hold
    @(posedge clk);
    #1;
    check_bit("done_clears", done, 1'b0);
    check_vec("q_hold", q, 16'h2233);
    check_bit("busy_idle", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_vec("q_hold_idle", q, 16'h2233);

    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h0009, 16'h0005, 1'b1);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h0000, 16'h0000, 1'b1);

    // start while busy is ignored; operands were latched at acceptance
    @(posedge clk);
    #1;
    e = model(16'h1111, 16'h2222, 1'b0);
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'h0F0F;
    ctrl  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op(3, e);
    @(posedge clk);
    #1;
    check_bit("ignored_no_done", done, 1'b0);
    check_bit("ignored_no_busy", busy, 1'b0);

    // reset two edges after acceptance aborts with cleared outputs
    op(16'h4321, 16'h1000, 1'b0);
    start_op(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_vec("abort_q", q, '0);
    check_bit("abort_c", c_final, 1'b0);
    check_bit("abort_zero", zero, 1'b0);
    for (int k = 0; k < NIBBLES + 2; k++) begin
      @(posedge clk);
      #1;
      check_bit("abort_no_done", done, 1'b0);
    end
    op(16'h0001, 16'h0001, 1'b0);

    // random operations; each starts in the previous done cycle
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (n % 6 == 0) rb = ra;
      op(ra, rb, rc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-precision add/subtract sequencer built on the team's 4-bit adder/subtractor stage.
- Widens the 4-bit stage to 4*NIBBLES bits by processing one nibble per clock, LSB nibble first, and chaining the carry/borrow between nibbles.
- Sits directly upstream of result consumers and downstream of operand sources. Reuses the 4-bit stage's ctrl semantics: 0 = add, 1 = subtract.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- ctrl  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; q/c_final/zero are valid from this cycle.
- q  output  W  result.
- c_final  output  1  final carry-out. For subtract, 1 = no borrow (a >= b unsigned).
- zero  output  1  q == 0.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy, done, q, c_final and zero all 0; internal operand, carry and index registers cleared. Reset has priority over everything. Reset mid-RUN aborts the operation, with no done pulse and outputs cleared.
- States: IDLE and RUN.
- IDLE with start=1 at an edge (accepting edge):
  - latch a, b, ctrl;
  - carry register := ctrl (the +1 of two's complement);
  - nibble index := 0; state := RUN; busy := 1.
- IDLE with start=0: hold.
- RUN, each edge, for nibble i = index:
  - s = a[4i+3:4i] + (ctrl ? ~b[4i+3:4i] : b[4i+3:4i]) + carry, a 5-bit sum;
  - partial[4i+3:4i] := s[3:0]; carry := s[4]; index := index+1.
- Completion, on the edge processing nibble NIBBLES-1:
  - q := full result; c_final := s[4]; zero := (full result == 0);
  - done := 1; busy := 0; state := IDLE.
- Latency: done is high exactly NIBBLES edges after the accepting edge. Throughput is one operation per NIBBLES+1 cycles at best.
- done is high for exactly one cycle. It is cleared on the next edge unless that edge completes another operation, which is impossible.
- start in the cycle where done=1: busy=0, so the request is accepted.
- start while busy=1 is ignored, with no queueing. a/b/ctrl changes during RUN have no effect (operands are latched).
- q, c_final and zero hold their values between completions. They are only written at completion or by reset.
- Arithmetic is modulo 2^W; the wrap-around result appears in q and the carry in c_final.
- The combinational path per cycle is one 4-bit slice only. No W-bit carry chain is permitted.

Optional Feature:
- Macro SIGNED_OVERFLOW_FLAG_EN.
- When defined: extra port ovf (output, 1 bit), reset 0, written only at completion.
  - ovf = carry into the MSB of the top nibble XOR carry out of it, i.e. two's-complement signed overflow of the W-bit operation.
  - Held between completions.
- When undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan (NIBBLES=4):
- Add: ctrl=0, a=0x1234, b=0x0FFF, start pulse -> done exactly 4 edges later with q=0x2233, c_final=0, zero=0, and busy high for those 4 cycles.
- Unsigned wrap: ctrl=0, a=0xFFFF, b=0x0001 -> q=0x0000, c_final=1, zero=1; with macro, ovf=0.
- Borrow: ctrl=1, a=0x0005, b=0x0007 -> q=0xFFFE, c_final=0. Then ctrl=1, a=0x0009, b=0x0005 -> q=0x0004, c_final=1.
- Signed overflow (macro defined): ctrl=1, a=0x8000, b=0x0001 -> q=0x7FFF, c_final=1, ovf=1. Also ctrl=0, a=0x7FFF, b=0x0001 -> q=0x8000, ovf=1.
- Busy/back-to-back handling:
  - start with new operands 2 cycles after acceptance is ignored, and q matches the first operation;
  - start asserted in the done cycle is accepted, with done again 4 edges later.
- Reset mid-operation: rst=1 two edges after acceptance -> busy=0, q=0, c_final=0, zero=0, and no done pulse.
  - A subsequent add 0x0001+0x0001 completes normally with q=0x0002.
